// File: rtl/led_mode_sequencer.sv
// Push-button mode sequencer driving three LEDs with tick-timed blink and chase patterns.
// Define LED_SEQ_DIM_EN to add the 25%-duty DIM mode after CHASE.
module led_mode_sequencer #(
  parameter int unsigned TICK_DIV = 5_000_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PRESS,
  output logic       LED0,
  output logic       LED1,
  output logic       LED2,
  output logic [2:0] MODE
);

  localparam int unsigned CNT_W = 23;

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_ON    = 3'd1,
    S_BLINK = 3'd2,
`ifdef LED_SEQ_DIM_EN
    S_CHASE = 3'd3,
    S_DIM   = 3'd4
`else
    S_CHASE = 3'd3
`endif
  } state_t;

  state_t           state;
  state_t           nxt_c;
  logic [CNT_W-1:0] tick_cnt;
  logic             tick_c;
  logic             blink_phase;
  logic [2:0]       chase;
  logic [2:0]       pat_c;
  logic [2:0]       led_q;
`ifdef LED_SEQ_DIM_EN
  logic [1:0]       pwm_cnt;
`endif

  assign tick_c = (tick_cnt == CNT_W'(TICK_DIV - 1));

  // Every PRESS cycle advances one state; unused encodings fall back to OFF.
  always_comb begin
    nxt_c = S_OFF;
    case (state)
      S_OFF:   nxt_c = PRESS ? S_ON    : S_OFF;
      S_ON:    nxt_c = PRESS ? S_BLINK : S_ON;
      S_BLINK: nxt_c = PRESS ? S_CHASE : S_BLINK;
`ifdef LED_SEQ_DIM_EN
      S_CHASE: nxt_c = PRESS ? S_DIM   : S_CHASE;
      S_DIM:   nxt_c = PRESS ? S_OFF   : S_DIM;
`else
      S_CHASE: nxt_c = PRESS ? S_OFF   : S_CHASE;
`endif
      default: nxt_c = S_OFF;
    endcase
  end

  // LED pattern for the current state, registered below.
  always_comb begin
    pat_c = 3'b000;
    case (state)
      S_ON:    pat_c = 3'b111;
      S_BLINK: pat_c = {3{blink_phase}};
      S_CHASE: pat_c = chase;
`ifdef LED_SEQ_DIM_EN
      S_DIM:   pat_c = {3{pwm_cnt == 2'd0}};
`endif
      default: pat_c = 3'b000;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_OFF;
      tick_cnt    <= '0;
      blink_phase <= 1'b1;
      chase       <= 3'b001;
      led_q       <= 3'b000;
`ifdef LED_SEQ_DIM_EN
      pwm_cnt     <= 2'd0;
`endif
    end else begin
      state <= nxt_c;
      led_q <= pat_c;
      // A state change restarts the prescaler and reloads entry patterns, discarding any tick.
      if (nxt_c != state) begin
        tick_cnt    <= '0;
        blink_phase <= 1'b1;
        chase       <= 3'b001;
      end else begin
        tick_cnt <= tick_c ? '0 : tick_cnt + CNT_W'(1);
        if (tick_c && state == S_BLINK) blink_phase <= ~blink_phase;
        if (tick_c && state == S_CHASE) chase <= {chase[1:0], chase[2]};
      end
`ifdef LED_SEQ_DIM_EN
      pwm_cnt <= (nxt_c == S_DIM && state != S_DIM) ? 2'd0 : pwm_cnt + 2'd1;
`endif
    end
  end

  assign MODE = state;
  assign LED0 = led_q[0];
  assign LED1 = led_q[1];
  assign LED2 = led_q[2];

endmodule

// File: doc/led_mode_sequencer.md
# led_mode_sequencer

Mode sequencer that consumes the single-cycle, debounced push-button press pulse produced by the switch filter stage and drives the three board LEDs. Each press advances a mode state machine (off, all-on, blink, chase, optionally dim). Per-mode patterns are timed by an internal prescaler tick. It replaces direct decoding of the press count into LED levels.

## Interface
- TICK_DIV, 5_000_000, CLK cycles per pattern tick (≥2); counter width 23 bits, so TICK_DIV ≤ 8_388_608
- CLK  input  1  system clock, all logic on posedge
- RST  input  1  synchronous, active-high reset
- PRESS  input  1  one-cycle press pulse from the debounce/edge-detect stage, already synchronous to CLK
- LED0  output  1  LED 0 drive, registered, 1 = lit
- LED1  output  1  LED 1 drive, registered
- LED2  output  1  LED 2 drive, registered
- MODE  output  3  current state encoding, registered

## Operation
- States and encodings:
  - S_OFF = 0
  - S_ON = 1
  - S_BLINK = 2
  - S_CHASE = 3
  - S_DIM = 4 (only with the macro)
- Transitions occur only on a cycle with PRESS=1:
  - OFF→ON→BLINK→CHASE→OFF without the macro.
  - CHASE→DIM→OFF with the macro.
- Any unused encoding → S_OFF on the next edge.
- PRESS is not re-qualified. Every cycle with PRESS=1 advances one state; a pulse held N cycles advances N states.
- Prescaler: tick_cnt counts 0..TICK_DIV-1 and wraps. tick=1 for the one cycle where tick_cnt==TICK_DIV-1.
- On any state change, tick_cnt clears to 0. Pattern registers load their entry values: blink_phase=1, chase=3'b001.
- Pattern per state:
  - OFF: LED2..0 = 000.
  - ON: LED2..0 = 111.
  - BLINK: all LEDs = blink_phase; blink_phase toggles on tick.
  - CHASE: LED2..0 = chase one-hot; rotates left on tick: 001→010→100→001.
  - DIM: see Configuration.
- LED outputs are registered from the current state and pattern registers, with no combinational path from PRESS.
- Reset (any time, including mid-pattern):
  - MODE=0, LED2..0=000.
  - tick_cnt=0, blink_phase=1, chase=001, pwm_cnt=0.

## Timing
- PRESS high at edge k:
  - MODE updates at edge k (visible after k).
  - LEDs show the new mode's entry pattern after edge k+1. Latency is 1 cycle to MODE and 2 cycles to LEDs.
- After entering BLINK or CHASE, the first tick occurs TICK_DIV cycles after the transition edge. The pattern register changes on that edge, and the LEDs follow one edge later.
- PRESS and tick in the same cycle: PRESS wins; the tick is discarded and the counters and patterns load entry values.
- Blink period = 2×TICK_DIV cycles, 50% duty.
- Chase full cycle = 3×TICK_DIV cycles.
- RST and PRESS in the same cycle: RST wins, MODE=0.

## Configuration
- LED_SEQ_DIM_EN defined:
  - Adds S_DIM and a free-running 2-bit pwm_cnt, incremented every CLK and cleared on entry to DIM.
  - In DIM, all LEDs = (pwm_cnt==0), i.e. a 25% duty, period 4 cycles.
  - CHASE→DIM→OFF.
- Not defined:
  - No pwm_cnt, no S_DIM.
  - CHASE→OFF, and encoding 4 is treated as an illegal state.

## Test plan (TICK_DIV=4)
- Reset, then release RST:
  - MODE=0, LEDs=000 for 20 cycles with PRESS=0.
- Four one-cycle PRESS pulses spaced 10 cycles apart:
  - MODE goes 1,2,3,0, each one cycle after its pulse.
  - LEDs are 111 after the ON press +2 cycles.
  - LEDs are 000 after the final press +2 cycles (macro undefined).
- Enter BLINK, PRESS then idle:
  - LEDs=111 for 4 cycles, then 000 for 4 cycles, then repeating.
  - The first toggle is visible 5 cycles after the MODE change.
- Enter CHASE:
  - LED2..0 sequence is 001, 010, 100, 001, each held 4 cycles.
  - A PRESS coinciding with a tick yields MODE=0 and no rotation.
- PRESS held high 3 cycles from OFF:
  - MODE=3.
- Apply RST mid-CHASE:
  - Next cycle MODE=0; LEDs=000 the cycle after.
- With LED_SEQ_DIM_EN:
  - From CHASE, PRESS → MODE=4; each LED is high exactly 1 of every 4 cycles.
  - Next PRESS → MODE=0.
